// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, round-key type and Rcon table.
package aes_pkg;

  localparam int unsigned AES_KEY_BITS = 128;
  localparam int unsigned AES_NUM_RK   = 11;

  typedef logic [AES_KEY_BITS-1:0] rk_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } ks_state_t;

  localparam logic [7:0] AES_RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-table indices yield 0 so the round input stays defined outside EXPAND.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (idx == 4'(i)) r = AES_RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational single AES-128 key-expansion round; w0 is the most significant word.
module aes_key_round (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  subbytes u_subbytes (
    .in_i  (rot_w3),
    .out_o (sub_w3)
  );

  assign n0 = sub_w3 ^ w0 ^ {rcon_i, 24'h0};
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/subbytes.sv
// 32-bit AES SubWord: four parallel S-boxes, each computed as GF(2^8) inverse + affine map.
module subbytes (
  input  logic [31:0] in_i,
  output logic [31:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    out_o = '0;
    for (int i = 0; i < 4; i++) begin
      out_o[8*i +: 8] = sbox(in_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller with an 11-entry round-key store and
// registered read port. Define AES_KEYSCHED_ZEROIZE_EN to add the zeroize input.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = AES_KEY_BITS,
  parameter int unsigned NUM_RK   = AES_NUM_RK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
`ifdef AES_KEYSCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic [3:0]          rd_addr,
  output logic [KEY_BITS-1:0] rd_data
);

  localparam logic [3:0] LastIdx = 4'(NUM_RK - 1);

  ks_state_t           state_q, state_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [KEY_BITS-1:0] rk_q [NUM_RK];
  logic [KEY_BITS-1:0] rk_d [NUM_RK];
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                keys_valid_q, keys_valid_d;
  logic [KEY_BITS-1:0] rd_data_q, rd_data_d;

  logic [KEY_BITS-1:0] prev_key, next_key, rd_sel;

  always_comb begin
    prev_key = '0;
    rd_sel   = '0;
    for (int i = 0; i < int'(NUM_RK); i++) begin
      if (rnd_q == 4'(i + 1)) prev_key = rk_q[i];
      if (rd_addr == 4'(i))   rd_sel   = rk_q[i];
    end
  end

  aes_key_round u_key_round (
    .key_i  (prev_key),
    .rcon_i (rcon_byte(rnd_q - 4'd1)),
    .key_o  (next_key)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    rk_d         = rk_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    rd_data_d    = (keys_valid_q && rd_addr <= LastIdx) ? rd_sel : '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rk_d[0]      = key_in;
          rnd_d        = 4'd1;
          keys_valid_d = 1'b0;
          ready_d      = 1'b0;
          busy_d       = 1'b1;
          state_d      = StExpand;
        end
      end
      StExpand: begin
        for (int i = 1; i < int'(NUM_RK); i++) begin
          if (rnd_q == 4'(i)) rk_d[i] = next_key;
        end
        // rnd saturates at the last index rather than wrapping.
        if (rnd_q == LastIdx) state_d = StDone;
        else                  rnd_d   = rnd_q + 4'd1;
      end
      StDone: begin
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
        ready_d      = 1'b1;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef AES_KEYSCHED_ZEROIZE_EN
    if (zeroize) begin
      for (int i = 0; i < int'(NUM_RK); i++) rk_d[i] = '0;
      state_d      = StIdle;
      rnd_d        = 4'd0;
      ready_d      = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      keys_valid_d = 1'b0;
      rd_data_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rnd_q        <= 4'd0;
      for (int i = 0; i < int'(NUM_RK); i++) rk_q[i] <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      rk_q         <= rk_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: a word-wise FIPS-197 expansion model predicts
// every cycle's handshake outputs and read data; a monitor compares them after each edge.
module tb_aes_key_sched_ctrl;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst, start, zeroize;
  logic [127:0] key_in;
  logic [3:0]   rd_addr;
  logic         ready, busy, done, keys_valid;
  logic [127:0] rd_data;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         done;
    logic         kv;
    logic [127:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: cycles left in the current run, published schedule, pending schedule.
  int                  m_cnt   = 0;
  logic                m_valid = 1'b0;
  logic                m_done  = 1'b0;
  logic [10:0][127:0]  m_keys  = '0;
  logic [10:0][127:0]  m_pend  = '0;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_HEX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0]        w [44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [10:0][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive inputs, predict the post-edge outputs, queue the prediction.
  task automatic cyc(input logic r, input logic s, input logic z, input logic [127:0] k,
                     input logic [3:0] a);
    exp_t e;
    logic zz;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    zz = z;
`else
    zz = 1'b0;
`endif
    @(negedge clk);
    rst = r; start = s; zeroize = z; key_in = k; rd_addr = a;
    e.rd = (!r && !zz && m_valid && a <= 4'd10) ? m_keys[a] : '0;
    if (r || zz) begin
      m_cnt = 0; m_valid = 1'b0; m_done = 1'b0;
    end else if (m_cnt == 0 && s) begin
      m_cnt = 11; m_valid = 1'b0; m_done = 1'b0; m_pend = expand(k);
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_keys  = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
    e.ready = (m_cnt == 0);
    e.busy  = (m_cnt != 0);
    e.done  = m_done;
    e.kv    = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rnd_key(), 4'($urandom_range(0, 15)));
  endtask

  task automatic load(input logic [127:0] k);
    cyc(1'b0, 1'b1, 1'b0, k, 4'($urandom_range(0, 15)));
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 1'b0, 1'b0, '0, 4'(a));
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) rd(a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready", {127'b0, ready}, {127'b0, e.ready});
        chk("busy", {127'b0, busy}, {127'b0, e.busy});
        chk("done", {127'b0, done}, {127'b0, e.done});
        chk("keys_valid", {127'b0, keys_valid}, {127'b0, e.kv});
        chk("rd_data", rd_data, e.rd);
      end
    end
  end

  initial begin : stim
    logic [10:0][127:0] ref_sched;
    rst = 1'b1; start = 1'b0; zeroize = 1'b0; key_in = '0; rd_addr = '0;

    ref_sched = expand(FIPS_KEY);
    chk("model_fips_rk1", ref_sched[1], FIPS_RK1);
    chk("model_fips_rk10", ref_sched[10], FIPS_RK10);
    ref_sched = expand('0);
    chk("model_zero_rk10", ref_sched[10], ZERO_RK10);

    cyc(1'b1, 1'b0, 1'b0, '0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, rnd_key(), 4'd3);
    idle(3);

    // FIPS-197 key, reads during and after the expansion.
    load(FIPS_KEY);
    idle(11);
    rd(1); rd(10); rd(0); rd(11);

    // start held high through EXPAND/DONE with changing keys.
    load(rnd_key());
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b0, rnd_key(), 4'($urandom_range(0, 15)));
    read_all();

    // Reset in the fifth EXPAND cycle, then an all-zero key.
    load(rnd_key());
    idle(4);
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd10);
    read_all();
    load('0);
    idle(11);
    rd(10); rd(0);

    // Second key loaded in the cycle ready returns.
    load(rnd_key());
    idle(11);
    load(rnd_key());
    for (int i = 0; i < 11; i++) rd(10);
    read_all();

    for (int n = 0; n < 4; n++) begin
      load(rnd_key());
      idle(11 + int'($urandom_range(0, 3)));
      idle(6);
    end

`ifdef AES_KEYSCHED_ZEROIZE_EN
    load(rnd_key());
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, rnd_key(), 4'd0);
    idle(13);
    read_all();
    load(rnd_key());
    idle(12);
    rd(5);
    cyc(1'b0, 1'b0, 1'b1, '0, 4'd5);
    read_all();
`endif

    @(posedge clk);
    #3;
    chk("scoreboard_drain", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. It accepts a cipher key through a start/ready handshake and drives one combinational key-expansion round per clock, ten rounds in total. It stores all 11 round keys in an internal key store and serves them to the cipher core through a registered random-access read port. It sits between the key-load interface and the round datapath, so the round datapath never recomputes keys.

## Interface
- `KEY_BITS`, 128: key and round-key width; only 128 is supported.
- `NUM_RK`, 11: number of stored round keys (rk0..rk10).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: key-load request; accepted only when `ready`=1.
- `key_in`  in  128: cipher key; word 0 is in bits [127:96]; sampled on accept.
- `ready`  out  1: controller idle and able to accept `start`.
- `busy`  out  1: expansion in progress.
- `done`  out  1: one-cycle pulse when rk10 has been written.
- `keys_valid`  out  1: the store holds a complete, consistent schedule.
- `rd_addr`  in  4: round-key index 0..10.
- `rd_data`  out  128: registered round key at `rd_addr`.
- `zeroize`  in  1: present only with `AES_KEYSCHED_ZEROIZE_EN`.

## Operation
- States: IDLE, EXPAND, DONE.
- **IDLE**
  - `ready`=1.
  - On `start`: rk0 <= `key_in`, `rnd` <= 1, `keys_valid` <= 0, go to EXPAND.
- **EXPAND**
  - Each cycle: rk[`rnd`] <= round(rk[`rnd`-1], rcon index `rnd`-1), then `rnd`++.
  - Rcon bytes in order: 01,02,04,08,10,20,40,80,1B,36. The Rcon byte is XORed into the most significant byte of word 0.
  - When rk10 is written, go to DONE.
- **DONE** (one cycle): `done`=1, `keys_valid` <= 1, go to IDLE.
- Round function, word-wise with w0 as the MSW:
  - w0' = SubWord(RotWord(w3)) ^ w0 ^ {rcon,24'h0}
  - w1' = w0' ^ w1
  - w2' = w1' ^ w2
  - w3' = w2' ^ w3
  - RotWord moves byte [31:24] to the bottom.
- `start` while not `ready` is ignored and never queued.
- A new `start` accepted from IDLE with `keys_valid`=1 clears `keys_valid` in the same edge. The old keys are then overwritten progressively.
- Read port:
  - `rd_data` <= (`keys_valid` && `rd_addr`<=10) ? rk[`rd_addr`] : 0.
  - Out-of-range addresses (11..15) return 0.
  - Reads during EXPAND return 0.
- `rnd` is 4 bits and never exceeds 10; there is no wrap-around.

## Timing
- Reset values:
  - State IDLE.
  - `ready`=1, `busy`=0, `done`=0, `keys_valid`=0, `rd_data`=0.
  - All rk entries 0, `rnd`=0.
- Accept on edge E0:
  - `busy`=1 and `ready`=0 in cycles E0+1..E0+11.
  - rk1..rk10 are written on edges E0+1..E0+10.
  - `done`=1 and `keys_valid`=1 are visible in the cycle after edge E0+11 (DONE→IDLE), i.e. `done` is registered.
  - Key-load to `done` latency: 12 cycles. `ready` returns with `done`.
- Read latency: 1 cycle (address sampled at edge N, data valid after edge N).
- `rst` mid-EXPAND: next cycle is fully at reset values; the partial schedule is discarded.
- `rst` and `start` together: `rst` wins.

## Configuration
- `AES_KEYSCHED_ZEROIZE_EN` defined:
  - Adds the `zeroize` input.
  - On the edge it is sampled high: all rk <= 0, `keys_valid` <= 0, `rd_data` <= 0, state <= IDLE. It aborts any expansion.
  - Priority: `rst` > `zeroize` > `start`.
  - `done` is never asserted for an aborted run.
- `AES_KEYSCHED_ZEROIZE_EN` undefined:
  - The port is absent.
  - The store is cleared only by `rst`.

## Structure
- Shared package `aes_pkg`:
  - state enum `ks_state_t` (IDLE/EXPAND/DONE)
  - `AES_NUM_RK`=11
  - Rcon byte table (10 entries)
  - round-key type `rk_t` (128-bit)
- One sub-module, `aes_key_round`: combinational single-round expansion with inputs (prev key, rcon byte). It reuses the existing 32-bit `subbytes` S-box instance for SubWord. The controller instantiates it once.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start → `done` 12 cycles after accept. Read rk1 = a0fafe1788542cb123a339392a6c7605 and rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read `rd_addr`=0 after `done` → 2b7e1516...09cf4f3c one cycle later. `rd_addr`=11 → 0. Any read during EXPAND → 0.
- `start` pulsed on every cycle during EXPAND → exactly one `done`. Keys match the first key; the later `key_in` values are ignored.
- Assert `rst` at cycle 5 of EXPAND → next cycle `ready`=1, `keys_valid`=0, all reads return 0. A restart with an all-zero key gives rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back load of a second key in the cycle `ready` returns → `keys_valid` drops on that edge. The new schedule is correct and the old rk10 is never readable.
- With `AES_KEYSCHED_ZEROIZE_EN`: `zeroize` at cycle 3 of EXPAND → IDLE, no `done` pulse, all rk read back as 0.
